// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: TD4 program loader and run/step/halt sequencer.
// Optional PC breakpoint unit: define TD4_BREAKPOINT_EN.
module td4_run_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [3:0]       cpu_pc,
  output logic             prog_we,
  output logic [3:0]       prog_addr,
  output logic [7:0]       prog_wdata,
  output logic             cpu_ce,
  output logic             cpu_rst_n,
  output logic [1:0]       state,
  output logic             err,
  output logic             bp_hit
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_CTRL = 2'd3;

  logic [1:0]       state_d;
  logic [3:0]       ptr, ptr_d;
  logic [DIV_W-1:0] div, div_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] cnt_nx, div_sel;
  logic             we_d, ce_d, rst_d;
  logic             err_d, hit_d;
  logic [3:0]       addr_d;
  logic [7:0]       wdata_d;

  logic xfer, ls_ok, is_ctrl;
  logic load_go, run_go, step_go;
  logic abort, halt_cmd, illegal;
  logic run_act, fire;
  logic bp_set, bp_stop;

  assign cmd_ready = ena & (state != S_STEP);
  assign xfer      = cmd_valid & cmd_ready;
  assign ls_ok     = (state == S_IDLE)
                   | (state == S_HALT);
  assign is_ctrl   = xfer & (cmd_op == OP_CTRL);

  assign load_go  = xfer & ls_ok
                  & (cmd_op == OP_LOAD);
  assign run_go   = xfer & ls_ok
                  & (cmd_op == OP_RUN);
  assign step_go  = xfer & ls_ok
                  & (cmd_op == OP_STEP);
  assign illegal  = xfer & ~ls_ok
                  & (cmd_op != OP_CTRL);
  assign abort    = is_ctrl & cmd_data[5];
  assign halt_cmd = is_ctrl & ~cmd_data[5]
                  & ~bp_set;

  // Pulse is registered, so it is raised on the edge where the
  // counter reaches the divisor; RUN acceptance is count zero.
  assign run_act = run_go
                 | (ena & (state == S_RUN)
                    & ~halt_cmd & ~abort);
  assign div_sel = run_go ? cmd_data[DIV_W-1:0] : div;
  assign cnt_nx  = (run_go || cnt == div)
                 ? '0 : cnt + DIV_W'(1);
  assign fire    = run_act & (cnt_nx == div_sel);

`ifdef TD4_BREAKPOINT_EN
  logic       bp_valid;
  logic [3:0] bp_addr;
  logic [3:0] pc_guess;

  assign bp_set   = is_ctrl & ~cmd_data[5]
                  & cmd_data[4];
  // A pulse in flight moves the pc before the new pulse lands;
  // assume sequential fetch for that instruction.
  assign pc_guess = cpu_pc + {3'b000, cpu_ce};
  assign bp_stop  = fire & bp_valid
                  & (pc_guess == bp_addr);

  // breakpoint address register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_valid <= 1'b0;
      bp_addr  <= 4'd0;
    end else if (abort) begin
      bp_valid <= 1'b0;
    end else if (bp_set) begin
      bp_valid <= 1'b1;
      bp_addr  <= cmd_data[3:0];
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
  assign bp_set    = 1'b0;
  assign bp_stop   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state;
    unique case (1'b1)
      abort,
      load_go:
        state_d = S_IDLE;
      run_go:
        state_d = bp_stop ? S_HALT : S_RUN;
      step_go:
        state_d = S_STEP;
      halt_cmd & (state == S_RUN):
        state_d = S_HALT;
      bp_stop & (state == S_RUN):
        state_d = S_HALT;
      ena & (state == S_STEP):
        state_d = S_HALT;
      default: ;
    endcase
  end

  // next values of registered outputs and datapath
  always_comb begin
    we_d    = 1'b0;
    addr_d  = prog_addr;
    wdata_d = prog_wdata;
    ptr_d   = ptr;
    div_d   = div;
    cnt_d   = cnt;
    err_d   = err;
    hit_d   = bp_hit;
    ce_d    = (fire & ~bp_stop) | step_go;
    rst_d   = (state_d != S_IDLE);
    if (load_go) begin
      we_d    = 1'b1;
      addr_d  = ptr;
      wdata_d = cmd_data;
      ptr_d   = ptr + 4'd1;
    end
    if (run_go)  div_d = cmd_data[DIV_W-1:0];
    if (run_act) cnt_d = cnt_nx;
    if (illegal) err_d = 1'b1;
    if (run_go | step_go) hit_d = 1'b0;
    if (bp_stop) hit_d = 1'b1;
    if (abort) begin
      ptr_d = 4'd0;
      err_d = 1'b0;
      hit_d = 1'b0;
      cnt_d = '0;
    end
  end

  // output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_we    <= 1'b0;
      prog_addr  <= 4'd0;
      prog_wdata <= 8'd0;
      cpu_ce     <= 1'b0;
      cpu_rst_n  <= 1'b0;
      err        <= 1'b0;
      bp_hit     <= 1'b0;
      ptr        <= 4'd0;
      div        <= '0;
      cnt        <= '0;
    end else begin
      prog_we    <= we_d;
      prog_addr  <= addr_d;
      prog_wdata <= wdata_d;
      cpu_ce     <= ce_d;
      cpu_rst_n  <= rst_d;
      err        <= err_d;
      bp_hit     <= hit_d;
      ptr        <= ptr_d;
      div        <= div_d;
      cnt        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb_td4_run_ctrl: directed vector table plus corner sequences.
// Expected values are hand-computed cycle by cycle.
module tb_td4_run_ctrl;

  localparam int LD = 0;
  localparam int RU = 1;
  localparam int ST = 2;
  localparam int CT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [3:0] pc_m;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       cpu_ce;
  logic       cpu_rst_n;
  logic [1:0] state;
  logic       err;
  logic       bp_hit;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  td4_run_ctrl #(.DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cpu_pc     (pc_m),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .cpu_ce     (cpu_ce),
    .cpu_rst_n  (cpu_rst_n),
    .state      (state),
    .err        (err),
    .bp_hit     (bp_hit)
  );

  // core pc model: +1 per executed pulse, cleared in core reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc_m <= 4'd0;
    else if (!cpu_rst_n) pc_m <= 4'd0;
    else if (cpu_ce)     pc_m <= pc_m + 4'd1;
  end

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic       en;
    logic       we;
    logic [3:0] a;
    logic [7:0] wd;
    logic       ce;
    logic       rst;
    logic [1:0] st;
    logic       er;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic ad(int v, int op, int d, int en,
                    int we, int a, int wd, int ce,
                    int rst, int st, int er, int rdy);
    vec_t r;
    r.v   = 1'(v);
    r.op  = 2'(op);
    r.d   = 8'(d);
    r.en  = 1'(en);
    r.we  = 1'(we);
    r.a   = 4'(a);
    r.wd  = 8'(wd);
    r.ce  = 1'(ce);
    r.rst = 1'(rst);
    r.st  = 2'(st);
    r.er  = 1'(er);
    r.rdy = 1'(rdy);
    tbl.push_back(r);
  endtask

  task automatic chk(string nm, int idx, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s [%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int v, int op, int d);
    cmd_valid = 1'(v);
    cmd_op    = 2'(op);
    cmd_data  = 8'(d);
  endtask

  initial begin
    int n;
    int seen[$];

    // LOAD 0x10..0x1F to addr 0..15, then a 17th wraps to 0
    for (int i = 0; i < 16; i++)
      ad(1, LD, 16 + i, 1, 1, i, 16 + i, 0, 0, 0, 0, 1);
    ad(1, LD, 'h99, 1, 1, 0, 'h99, 0, 0, 0, 0, 1);
    ad(0, LD, 0,    1, 0, 0, 'h99, 0, 0, 0, 0, 1);
    // RUN div=3: pulse in 4th cycle after acceptance
    ad(1, RU, 3, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 1, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 1, 1, 1, 0, 1);
    // illegal LOAD in RUN: dropped, err set
    ad(1, LD, 'hAA, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    // ena low: frozen, command not taken
    ad(0, LD, 0, 0, 0, 0, 'h99, 0, 1, 1, 1, 0);
    ad(1, RU, 5, 0, 0, 0, 'h99, 0, 1, 1, 1, 0);
    // resume with same phase
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 1, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 1, 1, 1);
    // halt on the edge the counter matches
    ad(1, CT, 0, 1, 0, 0, 'h99, 0, 1, 3, 1, 1);
    ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 3, 1, 1);
    // three single steps
    for (int i = 0; i < 3; i++) begin
      ad(1, ST, 0, 1, 0, 0, 'h99, 1, 1, 2, 1, 0);
      ad(0, LD, 0, 1, 0, 0, 'h99, 0, 1, 3, 1, 1);
    end
    // abort clears err and pointer
    ad(1, CT, 'h20, 1, 0, 0, 'h99, 0, 0, 0, 0, 1);
    ad(1, LD, 'h5C, 1, 1, 0, 'h5C, 0, 0, 0, 0, 1);
    ad(1, LD, 'h5D, 1, 1, 1, 'h5D, 0, 0, 0, 0, 1);
    // RUN div=0: pulse every cycle
    ad(1, RU, 0, 1, 0, 1, 'h5D, 1, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 1, 'h5D, 1, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 1, 'h5D, 1, 1, 1, 0, 1);
    ad(1, CT, 0, 1, 0, 1, 'h5D, 0, 1, 3, 0, 1);
    // RUN div=1 from HALT, illegal STEP inside
    ad(1, RU, 1, 1, 0, 1, 'h5D, 0, 1, 1, 0, 1);
    ad(0, LD, 0, 1, 0, 1, 'h5D, 1, 1, 1, 0, 1);
    ad(1, ST, 0, 1, 0, 1, 'h5D, 0, 1, 1, 1, 1);
    ad(0, LD, 0, 1, 0, 1, 'h5D, 1, 1, 1, 1, 1);
    ad(1, CT, 'h20, 1, 0, 1, 'h5D, 0, 0, 0, 0, 1);
    ad(1, CT, 0,    1, 0, 1, 'h5D, 0, 0, 0, 0, 1);

    // reset state
    ena = 1'b1;
    #12;
    chk("rst_state", 0, int'(state), 0);
    chk("rst_cpurst", 0, int'(cpu_rst_n), 0);
    chk("rst_ce", 0, int'(cpu_ce), 0);
    chk("rst_we", 0, int'(prog_we), 0);
    chk("rst_addr", 0, int'(prog_addr), 0);
    chk("rst_wdata", 0, int'(prog_wdata), 0);
    chk("rst_err", 0, int'(err), 0);
    chk("rst_bphit", 0, int'(bp_hit), 0);
    chk("rst_ready", 0, int'(cmd_ready), 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_data  = tbl[i].d;
      ena       = tbl[i].en;
      tick();
      chk("we", i, int'(prog_we), int'(tbl[i].we));
      chk("addr", i, int'(prog_addr), int'(tbl[i].a));
      chk("wdata", i, int'(prog_wdata), int'(tbl[i].wd));
      chk("ce", i, int'(cpu_ce), int'(tbl[i].ce));
      chk("cpurst", i, int'(cpu_rst_n), int'(tbl[i].rst));
      chk("state", i, int'(state), int'(tbl[i].st));
      chk("err", i, int'(err), int'(tbl[i].er));
      chk("ready", i, int'(cmd_ready), int'(tbl[i].rdy));
    end

    // async reset drops a pending write strobe
    drive(1, LD, 'h33);
    tick();
    chk("ld_we", 100, int'(prog_we), 1);
    chk("ld_wd", 100, int'(prog_wdata), 'h33);
    drive(0, LD, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_we", 101, int'(prog_we), 0);
    chk("arst_wd", 101, int'(prog_wdata), 0);
    #2 rst_n = 1'b1;

    // async reset mid-RUN with div=7
    drive(1, RU, 7);
    tick();
    chk("r7_state", 102, int'(state), 1);
    drive(0, LD, 0);
    tick();
    tick();
    tick();
    chk("r7_ce", 103, int'(cpu_ce), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 104, int'(state), 0);
    chk("arst_cpurst", 104, int'(cpu_rst_n), 0);
    chk("arst_ce", 104, int'(cpu_ce), 0);
    chk("arst_err", 104, int'(err), 0);
    #2 rst_n = 1'b1;
    drive(1, RU, 0);
    tick();
    chk("r0_ce", 105, int'(cpu_ce), 1);
    chk("r0_state", 105, int'(state), 1);
    drive(0, LD, 0);
    tick();
    chk("r0_ce2", 106, int'(cpu_ce), 1);

`ifdef TD4_BREAKPOINT_EN
    drive(1, CT, 'h20);
    tick();
    drive(1, CT, 'h15);
    tick();
    chk("bp_state", 107, int'(state), 0);
    drive(1, RU, 0);
    tick();
    drive(0, LD, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (cpu_ce) begin
        n++;
        seen.push_back(int'(pc_m));
      end
      tick();
    end
    chk("bp_pulses", 108, n, 5);
    foreach (seen[i])
      chk("bp_pc", 109 + i, seen[i], i);
    chk("bp_state", 120, int'(state), 3);
    chk("bp_hit", 120, int'(bp_hit), 1);
    chk("bp_pcend", 120, int'(pc_m), 5);
    drive(1, ST, 0);
    tick();
    chk("bp_step_ce", 121, int'(cpu_ce), 1);
    chk("bp_step_hit", 121, int'(bp_hit), 0);
    drive(0, LD, 0);
    tick();
    chk("bp_step_st", 122, int'(state), 3);
`else
    // data[4] falls through to halt
    drive(1, CT, 'h10);
    tick();
    chk("nobp_state", 107, int'(state), 3);
    chk("nobp_ce", 107, int'(cpu_ce), 0);
    chk("nobp_hit", 107, int'(bp_hit), 0);
    drive(0, LD, 0);
    tick();
    chk("nobp_ce2", 108, int'(cpu_ce), 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
